// File: rtl/effect_fifo_port.sv
// Effect-side FIFO endpoint: read one sample, apply switch-selected gain, write it back.
// Latency: read strobe 1 cycle after ready is sampled, result and write strobe 4 cycles after.
// Backpressure: while the return FIFO is full the result is held and no new read is issued.
module effect_fifo_port #(
    parameter int d_width = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [1:0]         sw,
    input  logic               i_data_ready,
    input  logic [d_width-1:0] i_data,
    input  logic               i_out_full,
    output logic               o_read_enable,
    output logic [d_width-1:0] o_data,
    output logic               o_data_valid,
    output logic [15:0]        o_sample_count
);

    typedef enum logic [2:0] {IDLE, READ, WAIT, PROC, WRITE} state_t;

    localparam logic [d_width-1:0] SAT_MAX = {1'b0, {(d_width-1){1'b1}}};
    localparam logic [d_width-1:0] SAT_MIN = {1'b1, {(d_width-1){1'b0}}};

    state_t                     state_q, state_nxt;
    logic                       data_rdy_q;
    logic signed [d_width-1:0]  sample_q;
    logic [1:0]                 mode_q;
    logic signed [d_width-1:0]  result;
    logic                       valid_nxt;
    logic [15:0]                count_q;

    assign o_sample_count = count_q;

    // Ready is registered so IDLE decides on it one edge later; the WRITE->IDLE
    // edge samples it too, which keeps back-to-back samples 5 cycles apart.
    always_comb begin
        state_nxt = state_q;
        unique case (state_q)
            IDLE:    if (data_rdy_q) state_nxt = READ;
            READ:    state_nxt = WAIT;
            WAIT:    state_nxt = PROC;
            PROC:    state_nxt = WRITE;
            WRITE:   if (o_data_valid) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Full is sampled on every edge that could launch the strobe; one strobe per sample.
    assign valid_nxt = !i_out_full &&
                       ((state_q == PROC) || ((state_q == WRITE) && !o_data_valid));

    always_comb begin
        result = sample_q;
        unique case (mode_q)
            2'b01: result = sample_q >>> 1;
            2'b10: begin
                if (sample_q[d_width-1] != sample_q[d_width-2])
                    result = sample_q[d_width-1] ? SAT_MIN : SAT_MAX;
                else
                    result = {sample_q[d_width-2:0], 1'b0};
            end
            2'b11: result = (sample_q == SAT_MIN) ? SAT_MAX : -sample_q;
            default: result = sample_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            data_rdy_q    <= 1'b0;
            o_read_enable <= 1'b0;
            o_data_valid  <= 1'b0;
            o_data        <= '0;
            sample_q      <= '0;
            mode_q        <= 2'b00;
            count_q       <= 16'h0000;
        end else begin
            state_q       <= state_nxt;
            data_rdy_q    <= i_data_ready;
            o_read_enable <= (state_nxt == READ);
            o_data_valid  <= valid_nxt;
            if (state_q == WAIT) begin
                sample_q <= i_data;
                mode_q   <= sw;
            end
            if (state_q == PROC)
                o_data <= result;
            if ((state_q == WRITE) && o_data_valid)
                count_q <= count_q + 16'h0001;
        end
    end

endmodule

// File: tb/tb_effect_fifo_port.sv
// Directed bench for effect_fifo_port: reset, gain modes, backpressure, streaming, reset abort, count wrap.
`timescale 1ns/1ps
module tb_effect_fifo_port;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  sw;
    logic        i_data_ready;
    logic [15:0] i_data;
    logic        i_out_full;
    logic        o_read_enable;
    logic [15:0] o_data;
    logic        o_data_valid;
    logic [15:0] o_sample_count;

    int errors = 0;
    int checks = 0;

    effect_fifo_port #(.d_width(16)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .sw             (sw),
        .i_data_ready   (i_data_ready),
        .i_data         (i_data),
        .i_out_full     (i_out_full),
        .o_read_enable  (o_read_enable),
        .o_data         (o_data),
        .o_data_valid   (o_data_valid),
        .o_sample_count (o_sample_count)
    );

    always #20 clk = ~clk;

    function automatic logic [15:0] exp_fx(input logic [15:0] x, input logic [1:0] m);
        int v;
        int r;
        v = int'($signed(x));
        case (m)
            2'd0:    r = v;
            2'd1:    r = (v - (v & 1)) / 2;
            2'd2:    r = v * 2;
            default: r = -v;
        endcase
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        return 16'(r);
    endfunction

    // Launches one sample from IDLE; n counts falling edges after the edge that samples ready.
    task automatic run_sample(input logic [15:0] word, input logic [1:0] mode,
                              output logic [15:0] dout, output int rd_n, output int vld_n,
                              output int rd_cnt, output int vld_cnt);
        @(negedge clk);
        i_data = word; sw = mode; i_data_ready = 1'b1;
        rd_n = -1; vld_n = -1; rd_cnt = 0; vld_cnt = 0; dout = 16'hxxxx;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (n == 1) i_data_ready = 1'b0;
            if (o_read_enable) begin rd_cnt++; if (rd_n < 0) rd_n = n; end
            if (o_data_valid) begin
                vld_cnt++;
                if (vld_n < 0) begin vld_n = n; dout = o_data; end
            end
        end
    endtask

    task automatic test_reset();
        int rd_n = -1;
        int rd_cnt = 0;
        reset_n = 1'b0; i_data_ready = 1'b1; i_out_full = 1'b0; sw = 2'b00; i_data = 16'h0000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (o_read_enable !== 1'b0) begin errors++; $display("FAIL rst_read got=%b exp=0", o_read_enable); end
            checks++; if (o_data_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", o_data_valid); end
            checks++; if (o_data !== 16'h0000) begin errors++; $display("FAIL rst_data got=%h exp=0000", o_data); end
            checks++; if (o_sample_count !== 16'h0000) begin errors++; $display("FAIL rst_count got=%h exp=0000", o_sample_count); end
        end
        reset_n = 1'b1;
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            if (n == 1) i_data_ready = 1'b0;
            if (o_read_enable) begin rd_cnt++; if (rd_n < 0) rd_n = n; end
        end
        checks++; if (rd_n !== 2) begin errors++; $display("FAIL rst_first_read_edge got=%0d exp=2", rd_n); end
        checks++; if (rd_cnt !== 1) begin errors++; $display("FAIL rst_read_width got=%0d exp=1", rd_cnt); end
        repeat (6) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_bypass();
        logic [15:0] dout;
        int rd_n, vld_n, rd_cnt, vld_cnt;
        run_sample(16'h1234, 2'b00, dout, rd_n, vld_n, rd_cnt, vld_cnt);
        checks++; if (dout !== 16'h1234) begin errors++; $display("FAIL bypass_data got=%h exp=1234", dout); end
        checks++; if (rd_n !== 2) begin errors++; $display("FAIL bypass_read_edge got=%0d exp=2", rd_n); end
        checks++; if (vld_n !== 5) begin errors++; $display("FAIL bypass_valid_edge got=%0d exp=5", vld_n); end
        checks++; if (vld_cnt !== 1) begin errors++; $display("FAIL bypass_valid_width got=%0d exp=1", vld_cnt); end
        checks++; if (rd_cnt !== 1) begin errors++; $display("FAIL bypass_read_count got=%0d exp=1", rd_cnt); end
        checks++; if (o_sample_count !== 16'd1) begin errors++; $display("FAIL bypass_count got=%0d exp=1", o_sample_count); end
    endtask

    task automatic test_gain();
        logic [15:0] vin [7] = '{16'h4000, 16'hC000, 16'h1000, 16'hFFFF, 16'h0003, 16'h8000, 16'h0001};
        logic [1:0]  vm  [7] = '{2'b10, 2'b10, 2'b10, 2'b01, 2'b01, 2'b11, 2'b11};
        logic [15:0] vexp[7] = '{16'h7FFF, 16'h8000, 16'h2000, 16'hFFFF, 16'h0001, 16'h7FFF, 16'hFFFF};
        logic [15:0] dout;
        int rd_n, vld_n, rd_cnt, vld_cnt;
        for (int i = 0; i < 7; i++) begin
            run_sample(vin[i], vm[i], dout, rd_n, vld_n, rd_cnt, vld_cnt);
            checks++;
            if (dout !== vexp[i]) begin
                errors++; $display("FAIL gain_%0d in=%h sw=%b got=%h exp=%h", i, vin[i], vm[i], dout, vexp[i]);
            end
        end
        checks++; if (o_sample_count !== 16'd8) begin errors++; $display("FAIL gain_count got=%0d exp=8", o_sample_count); end
    endtask

    task automatic test_backpressure();
        int first_vld = -1;
        int rd2 = -1;
        int vcnt = 0;
        @(negedge clk);
        i_out_full = 1'b1; i_data = 16'h0777; sw = 2'b00; i_data_ready = 1'b1;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (n >= 5 && n <= 14) begin
                checks++; if (o_data_valid !== 1'b0) begin errors++; $display("FAIL bp_no_strobe n=%0d got=%b exp=0", n, o_data_valid); end
                checks++; if (o_read_enable !== 1'b0) begin errors++; $display("FAIL bp_no_read n=%0d got=%b exp=0", n, o_read_enable); end
                checks++; if (o_data !== 16'h0777) begin errors++; $display("FAIL bp_data_hold n=%0d got=%h exp=0777", n, o_data); end
            end
            if (n == 14) i_out_full = 1'b0;
            if (o_data_valid) begin vcnt++; if (first_vld < 0) first_vld = n; end
            if (o_read_enable && n > 2 && rd2 < 0) begin rd2 = n; i_data_ready = 1'b0; end
        end
        checks++; if (first_vld !== 15) begin errors++; $display("FAIL bp_strobe_edge got=%0d exp=15", first_vld); end
        checks++; if (rd2 !== 17) begin errors++; $display("FAIL bp_next_read_edge got=%0d exp=17", rd2); end
        checks++; if (vcnt !== 2) begin errors++; $display("FAIL bp_strobe_count got=%0d exp=2", vcnt); end
        checks++; if (o_sample_count !== 16'd10) begin errors++; $display("FAIL bp_count got=%0d exp=10", o_sample_count); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] words[$];
        logic [1:0]  modes[$];
        logic [15:0] w;
        logic [1:0]  m;
        int reads = 0, writes = 0, last_rd = -1, cap_at = -1, cyc = 0, extra = 0;
        @(negedge clk);
        i_out_full = 1'b0; i_data_ready = 1'b1;
        while (writes < 100 && cyc < 700) begin
            @(negedge clk);
            cyc++;
            if (o_data_valid) begin
                checks++;
                if (o_data !== exp_fx(words[writes], modes[writes])) begin
                    errors++; $display("FAIL stream_data idx=%0d got=%h exp=%h", writes, o_data, exp_fx(words[writes], modes[writes]));
                end
                writes++;
            end
            if (cap_at == cyc) sw = ~modes[reads-1];
            if (o_read_enable) begin
                if (last_rd >= 0) begin
                    checks++;
                    if (cyc - last_rd !== 5) begin errors++; $display("FAIL stream_read_gap idx=%0d got=%0d exp=5", reads, cyc - last_rd); end
                end
                last_rd = cyc;
                w = 16'(reads * 1237 + 32768);
                m = 2'(reads);
                words.push_back(w); modes.push_back(m);
                i_data = w; sw = m; cap_at = cyc + 2;
                reads++;
                if (reads == 100) i_data_ready = 1'b0;
            end
        end
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (o_read_enable || o_data_valid) extra++;
        end
        checks++; if (writes !== 100) begin errors++; $display("FAIL stream_writes got=%0d exp=100", writes); end
        checks++; if (reads !== 100) begin errors++; $display("FAIL stream_reads got=%0d exp=100", reads); end
        checks++; if (extra !== 0) begin errors++; $display("FAIL stream_extra_strobes got=%0d exp=0", extra); end
        checks++; if (o_sample_count !== 16'd110) begin errors++; $display("FAIL stream_count got=%0d exp=110", o_sample_count); end
    endtask

    task automatic test_reset_mid_proc();
        int strobes = 0;
        @(negedge clk);
        i_data = 16'h5555; sw = 2'b00; i_data_ready = 1'b1;
        @(negedge clk);
        i_data_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++; if (o_data !== 16'h0000) begin errors++; $display("FAIL midrst_data got=%h exp=0000", o_data); end
        checks++; if (o_sample_count !== 16'h0000) begin errors++; $display("FAIL midrst_count got=%h exp=0000", o_sample_count); end
        checks++; if (o_data_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got=%b exp=0", o_data_valid); end
        @(negedge clk);
        reset_n = 1'b1;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (o_read_enable || o_data_valid) strobes++;
        end
        checks++; if (strobes !== 0) begin errors++; $display("FAIL midrst_dropped got=%0d exp=0", strobes); end
        checks++; if (o_sample_count !== 16'h0000) begin errors++; $display("FAIL midrst_count_after got=%h exp=0000", o_sample_count); end
    endtask

    task automatic test_count_wrap();
        logic [15:0] dout;
        int rd_n, vld_n, rd_cnt, vld_cnt;
        @(negedge clk);
        force dut.count_q = 16'hFFFF;
        #1;
        release dut.count_q;
        @(negedge clk);
        checks++; if (o_sample_count !== 16'hFFFF) begin errors++; $display("FAIL wrap_preload got=%h exp=ffff", o_sample_count); end
        run_sample(16'h0002, 2'b10, dout, rd_n, vld_n, rd_cnt, vld_cnt);
        checks++; if (dout !== 16'h0004) begin errors++; $display("FAIL wrap_data got=%h exp=0004", dout); end
        checks++; if (o_sample_count !== 16'h0000) begin errors++; $display("FAIL wrap_count got=%h exp=0000", o_sample_count); end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_gain();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_proc();
        test_count_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
